// File: rtl/mod15_cmd_sequencer.sv
// Buffers LOAD/COUNT commands in a small FIFO and replays each one cycle-accurately
// onto the load/mode/data pins of a downstream mod-15 counter.
module mod15_cmd_sequencer #(
  parameter int DEPTH = 4,
  parameter int LEN_W = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [1:0]               cmd_op,
  input  logic [3:0]               cmd_data,
  input  logic [LEN_W-1:0]         cmd_len,
  output logic                     load,
  output logic                     mode,
  output logic [3:0]               data,
  output logic                     busy,
  output logic                     done,
  output logic                     err,
  output logic [$clog2(DEPTH):0]   fifo_level
);

  localparam int AW = $clog2(DEPTH);
  localparam int EW = 2 + 4 + LEN_W;
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_LOAD  = 2'd1;
  localparam logic [1:0] S_COUNT = 2'd2;
  localparam logic [1:0] S_ERR   = 2'd3;

  logic [EW-1:0]    mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      level;
  logic             push_d;
  logic [1:0]       state;
  logic [LEN_W-1:0] cnt;

  logic             push;
  logic             pop;
  logic             avail;
  logic             last;
  logic [1:0]       h_op;
  logic [3:0]       h_data;
  logic [LEN_W-1:0] h_len;
  logic [LEN_W-1:0] h_last;

  assign cmd_ready  = (level != FULL);
  assign push       = cmd_valid && cmd_ready;
  assign fifo_level = level;
  assign busy       = (state != S_IDLE) || (level != '0);

  // The entry written on the previous edge is not yet eligible, which gives the
  // two-edge accept-to-drive latency; older entries sit ahead of it in order.
  assign avail = push_d ? (level > (AW+1)'(1)) : (level != '0);
  assign last  = (state == S_LOAD) || (state == S_ERR) ||
                 ((state == S_COUNT) && (cnt == '0));
  assign pop   = avail && ((state == S_IDLE) || last);

  assign {h_op, h_data, h_len} = mem[rd_ptr];
  assign h_last = (h_len == '0) ? '0 : h_len - 1'b1;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {cmd_op, cmd_data, cmd_len};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      push_d <= 1'b0;
    end else begin
      push_d <= push;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      level <= level + 1'b1;
      else if (!push && pop) level <= level - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      cnt   <= '0;
      load  <= 1'b0;
      mode  <= 1'b1;
      data  <= 4'd0;
      done  <= 1'b0;
      err   <= 1'b0;
    end else begin
      load <= 1'b0;
      done <= 1'b0;
      err  <= 1'b0;
      if (pop) begin
        case (h_op)
          2'b00: begin
            if (h_data != 4'hF) begin
              state <= S_LOAD;
              load  <= 1'b1;
              data  <= h_data;
              done  <= 1'b1;
            end else begin
              state <= S_ERR;
              err   <= 1'b1;
            end
          end
          2'b01, 2'b10: begin
            state <= S_COUNT;
            mode  <= (h_op == 2'b01);
            cnt   <= h_last;
            done  <= (h_last == '0);
          end
          default: begin
            state <= S_ERR;
            err   <= 1'b1;
          end
        endcase
      end else if ((state == S_COUNT) && (cnt != '0)) begin
        cnt  <= cnt - 1'b1;
        done <= (cnt == LEN_W'(1));
      end else if (last) begin
        state <= S_IDLE;
      end
    end
  end

endmodule
